rename_regfile: RTL and testbench

Parametrised architectural register file with per-register rename state for the out-of-order RISC-V core. Each register holds a value, a busy bit and the ROB tag of its youngest in-flight producer. Decode/issue marks destinations busy, and ROB commit writes values back. Multiple read ports give issue the operand value, or the tag to wait on, with same-cycle commit bypass. A flush clears all rename state on branch mispredict.

---
 rtl/rename_regfile_pkg.sv | 15 +
 rtl/rf_read_port.sv | 24 ++
 rtl/rename_regfile.sv | 60 ++++++
 tb/tb_rename_regfile.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg: shared widths, types and the per-register rename entry.
package rename_regfile_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int TAG_W = 4;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [XLEN-1:0] word_t;
  typedef struct packed {
    word_t value;
    logic busy;
    rob_tag_t tag;
  } rf_entry_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with same-cycle commit bypass.
module rf_read_port
  import rename_regfile_pkg::*;
(
  input  reg_idx_t                   idx,
  input  rf_entry_t [NUM_REGS-1:0]   regs,
  input  logic                       commit_on,
  input  reg_idx_t                   commit_rd,
  input  rob_tag_t                   commit_tag,
  input  word_t                      commit_val,
  output word_t                      val,
  output logic                       busy,
  output rob_tag_t                   tag
);
  rf_entry_t e;
  logic byp;
  always_comb begin
    e = (idx == '0) ? '0 : regs[idx];
    byp = commit_on && commit_rd == idx && e.busy && e.tag == commit_tag;
    val = byp ? commit_val : e.value;
    busy = e.busy && !byp;
    tag = busy ? e.tag : '0;
  end
endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with busy/tag rename state and commit bypass.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              rdy_in,
  input  logic                              flush_in,
  input  logic                              issue_en_in,
  input  logic [REG_IDX_W-1:0]              issue_rd_in,
  input  logic [TAG_W-1:0]                  issue_tag_in,
  input  logic                              commit_en_in,
  input  logic [REG_IDX_W-1:0]              commit_rd_in,
  input  logic [TAG_W-1:0]                  commit_tag_in,
  input  logic [XLEN-1:0]                   commit_val_in,
  input  logic [NUM_RD_PORTS*REG_IDX_W-1:0] rd_idx_in,
  output logic [NUM_RD_PORTS*XLEN-1:0]      rd_val_out,
  output logic [NUM_RD_PORTS-1:0]           rd_busy_out,
  output logic [NUM_RD_PORTS*TAG_W-1:0]     rd_tag_out
);
  rf_entry_t [NUM_REGS-1:0] regs, regs_nxt;
  always_comb begin
    regs_nxt = regs;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (commit_en_in && commit_rd_in == reg_idx_t'(i)) begin
        regs_nxt[i].value = commit_val_in;
        if (regs[i].busy && regs[i].tag == commit_tag_in) begin
          regs_nxt[i].busy = 1'b0;
          regs_nxt[i].tag = '0;
        end
      end
      if (issue_en_in && issue_rd_in == reg_idx_t'(i)) begin
        regs_nxt[i].busy = 1'b1;
        regs_nxt[i].tag = issue_tag_in;
      end
      if (flush_in) begin
        regs_nxt[i].busy = 1'b0;
        regs_nxt[i].tag = '0;
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) regs <= '0;
    else if (rdy_in) regs <= regs_nxt;
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    rf_read_port u_port (
      .idx        (rd_idx_in[p*REG_IDX_W +: REG_IDX_W]),
      .regs       (regs),
      .commit_on  (rdy_in && commit_en_in),
      .commit_rd  (commit_rd_in),
      .commit_tag (commit_tag_in),
      .commit_val (commit_val_in),
      .val        (rd_val_out[p*XLEN +: XLEN]),
      .busy       (rd_busy_out[p]),
      .tag        (rd_tag_out[p*TAG_W +: TAG_W])
    );
  end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed scenario tests for rename_regfile with hand-computed expectations.
module tb_rename_regfile;
  logic clk = 0, rst_n = 0, rdy = 1, flush = 0;
  logic issue_en = 0, commit_en = 0;
  logic [4:0] issue_rd = 0, commit_rd = 0, idx0 = 0, idx1 = 0;
  logic [3:0] issue_tag = 0, commit_tag = 0;
  logic [31:0] commit_val = 0;
  logic [63:0] rd_val;
  logic [1:0] rd_busy;
  logic [7:0] rd_tag;
  int tests = 0, fails = 0;
  wire [31:0] v0 = rd_val[31:0], v1 = rd_val[63:32];
  wire b0 = rd_busy[0], b1 = rd_busy[1];
  wire [3:0] t0 = rd_tag[3:0], t1 = rd_tag[7:4];

  always #5 clk = ~clk;

  rename_regfile #(.NUM_RD_PORTS(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .issue_en_in(issue_en), .issue_rd_in(issue_rd), .issue_tag_in(issue_tag),
    .commit_en_in(commit_en), .commit_rd_in(commit_rd), .commit_tag_in(commit_tag),
    .commit_val_in(commit_val), .rd_idx_in({idx1, idx0}),
    .rd_val_out(rd_val), .rd_busy_out(rd_busy), .rd_tag_out(rd_tag)
  );

  task automatic step();
    @(posedge clk);
    #1;
    issue_en = 0;
    commit_en = 0;
    flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idx0 = 5;
    idx1 = 5;
    #2;
    tests++; if ({v0, b0, t0} !== 37'd0) begin fails++; $display("FAIL reset_p0: got %h/%b/%h exp 0/0/0", v0, b0, t0); end
    tests++; if ({v1, b1, t1} !== 37'd0) begin fails++; $display("FAIL reset_p1: got %h/%b/%h exp 0/0/0", v1, b1, t1); end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_issue_commit();
    issue_en = 1; issue_rd = 5; issue_tag = 3;
    step();
    idx0 = 5;
    #1;
    tests++; if ({v0, b0, t0} !== {32'h0, 1'b1, 4'd3}) begin fails++; $display("FAIL issue_busy: got %h/%b/%h exp 0/1/3", v0, b0, t0); end
    commit_en = 1; commit_rd = 5; commit_tag = 3; commit_val = 32'hDEADBEEF;
    #1;
    tests++; if ({v0, b0, t0} !== {32'hDEADBEEF, 1'b0, 4'd0}) begin fails++; $display("FAIL commit_bypass: got %h/%b/%h exp deadbeef/0/0", v0, b0, t0); end
    step();
    tests++; if ({v0, b0, t0} !== {32'hDEADBEEF, 1'b0, 4'd0}) begin fails++; $display("FAIL commit_stored: got %h/%b/%h exp deadbeef/0/0", v0, b0, t0); end
  endtask

  task automatic test_stale_commit();
    issue_en = 1; issue_rd = 7; issue_tag = 2;
    step();
    issue_en = 1; issue_rd = 7; issue_tag = 6;
    step();
    idx1 = 7;
    commit_en = 1; commit_rd = 7; commit_tag = 2; commit_val = 32'h11;
    #1;
    tests++; if ({v1, b1, t1} !== {32'h0, 1'b1, 4'd6}) begin fails++; $display("FAIL stale_no_bypass: got %h/%b/%h exp 0/1/6", v1, b1, t1); end
    step();
    tests++; if ({v1, b1, t1} !== {32'h11, 1'b1, 4'd6}) begin fails++; $display("FAIL stale_commit: got %h/%b/%h exp 11/1/6", v1, b1, t1); end
    commit_en = 1; commit_rd = 7; commit_tag = 6; commit_val = 32'h22;
    step();
    tests++; if ({v1, b1, t1} !== {32'h22, 1'b0, 4'd0}) begin fails++; $display("FAIL young_commit: got %h/%b/%h exp 22/0/0", v1, b1, t1); end
  endtask

  task automatic test_same_cycle();
    issue_en = 1; issue_rd = 9; issue_tag = 1;
    step();
    idx0 = 9;
    issue_en = 1; issue_rd = 9; issue_tag = 4;
    commit_en = 1; commit_rd = 9; commit_tag = 1; commit_val = 32'h55;
    #1;
    tests++; if ({v0, b0, t0} !== {32'h55, 1'b0, 4'd0}) begin fails++; $display("FAIL same_cycle_bypass: got %h/%b/%h exp 55/0/0", v0, b0, t0); end
    step();
    tests++; if ({v0, b0, t0} !== {32'h55, 1'b1, 4'd4}) begin fails++; $display("FAIL issue_wins: got %h/%b/%h exp 55/1/4", v0, b0, t0); end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 4; r++) begin
      issue_en = 1; issue_rd = 5'(r); issue_tag = 4'(r + 8);
      step();
    end
    idx0 = 3;
    #1;
    tests++; if ({b0, t0} !== {1'b1, 4'd11}) begin fails++; $display("FAIL pre_flush_busy: got %b/%h exp 1/b", b0, t0); end
    flush = 1;
    issue_en = 1; issue_rd = 8; issue_tag = 5;
    commit_en = 1; commit_rd = 2; commit_tag = 4'd15; commit_val = 32'hAB;
    step();
    for (int r = 1; r <= 4; r++) begin
      idx0 = 5'(r);
      #1;
      tests++; if ({b0, t0} !== 5'd0) begin fails++; $display("FAIL flush_x%0d: got %b/%h exp 0/0", r, b0, t0); end
    end
    idx0 = 8; idx1 = 9;
    #1;
    tests++; if ({v0, b0, t0} !== 37'd0) begin fails++; $display("FAIL flush_drops_issue: got %h/%b/%h exp 0/0/0", v0, b0, t0); end
    tests++; if ({v1, b1, t1} !== {32'h55, 1'b0, 4'd0}) begin fails++; $display("FAIL flush_keeps_x9: got %h/%b/%h exp 55/0/0", v1, b1, t1); end
    idx0 = 2; idx1 = 5;
    #1;
    tests++; if (v0 !== 32'hAB) begin fails++; $display("FAIL flush_commit_val: got %h exp ab", v0); end
    tests++; if ({v1, b1} !== {32'hDEADBEEF, 1'b0}) begin fails++; $display("FAIL flush_keeps_x5: got %h/%b exp deadbeef/0", v1, b1); end
  endtask

  task automatic test_x0();
    idx0 = 0;
    issue_en = 1; issue_rd = 0; issue_tag = 7;
    commit_en = 1; commit_rd = 0; commit_tag = 0; commit_val = 32'h1234;
    #1;
    tests++; if ({v0, b0, t0} !== 37'd0) begin fails++; $display("FAIL x0_same_cycle: got %h/%b/%h exp 0/0/0", v0, b0, t0); end
    step();
    tests++; if ({v0, b0, t0} !== 37'd0) begin fails++; $display("FAIL x0_after: got %h/%b/%h exp 0/0/0", v0, b0, t0); end
  endtask

  task automatic test_rdy_low();
    issue_en = 1; issue_rd = 9; issue_tag = 3;
    step();
    rdy = 0;
    idx0 = 9; idx1 = 3;
    issue_en = 1; issue_rd = 3; issue_tag = 5;
    commit_en = 1; commit_rd = 9; commit_tag = 3; commit_val = 32'h77;
    #1;
    tests++; if ({v0, b0, t0} !== {32'h55, 1'b1, 4'd3}) begin fails++; $display("FAIL rdy_no_bypass: got %h/%b/%h exp 55/1/3", v0, b0, t0); end
    @(posedge clk);
    #1;
    tests++; if ({v1, b1, t1} !== {32'h0, 1'b0, 4'd0}) begin fails++; $display("FAIL rdy_frozen_x3: got %h/%b/%h exp 0/0/0", v1, b1, t1); end
    tests++; if ({v0, b0, t0} !== {32'h55, 1'b1, 4'd3}) begin fails++; $display("FAIL rdy_frozen_x9: got %h/%b/%h exp 55/1/3", v0, b0, t0); end
    issue_en = 0; commit_en = 0;
    rdy = 1;
  endtask

  task automatic test_reset_mid();
    issue_en = 1; issue_rd = 10; issue_tag = 2;
    step();
    idx0 = 9; idx1 = 10;
    #1;
    tests++; if ({b1, t1} !== {1'b1, 4'd2}) begin fails++; $display("FAIL pre_reset_x10: got %b/%h exp 1/2", b1, t1); end
    rst_n = 0;
    #1;
    tests++; if ({v0, b0, t0} !== 37'd0) begin fails++; $display("FAIL async_reset_x9: got %h/%b/%h exp 0/0/0", v0, b0, t0); end
    tests++; if ({v1, b1, t1} !== 37'd0) begin fails++; $display("FAIL async_reset_x10: got %h/%b/%h exp 0/0/0", v1, b1, t1); end
    @(negedge clk);
    rst_n = 1;
    issue_en = 1; issue_rd = 11; issue_tag = 1;
    step();
    idx0 = 11; idx1 = 5;
    #1;
    tests++; if ({v0, b0, t0} !== {32'h0, 1'b1, 4'd1}) begin fails++; $display("FAIL post_reset_issue: got %h/%b/%h exp 0/1/1", v0, b0, t0); end
    tests++; if ({v1, b1, t1} !== 37'd0) begin fails++; $display("FAIL post_reset_x5: got %h/%b/%h exp 0/0/0", v1, b1, t1); end
  endtask

  initial begin
    test_reset();
    test_issue_commit();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_x0();
    test_rdy_low();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
